// File: rtl/conv_layer_seq.sv
// Sequential single-precision convolution layer.
// One multiply-accumulate tap per clock for all K filters in parallel.
// Windows are visited in raster order, and each result word is written once.

// Combinational single-precision multiplier.
// Subnormals are treated as zero. Rounding is round-to-nearest-even.
module floatMult (
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [31:0] y
);
    logic              sign;
    logic              a_zero, b_zero, a_inf, b_inf, a_nan, b_nan;
    logic [47:0]       prod;
    logic [22:0]       mant;
    logic              guard, sticky, rnd;
    logic [23:0]       mant_rnd;
    logic signed [9:0] exp;

    // Multiply the significands, normalise by at most one place, round, then resolve special operands.
    always_comb begin
        sign   = a[31] ^ b[31];
        a_zero = (a[30:23] == 8'd0);
        b_zero = (b[30:23] == 8'd0);
        a_inf  = (a[30:23] == 8'hFF) && (a[22:0] == 23'd0);
        b_inf  = (b[30:23] == 8'hFF) && (b[22:0] == 23'd0);
        a_nan  = (a[30:23] == 8'hFF) && (a[22:0] != 23'd0);
        b_nan  = (b[30:23] == 8'hFF) && (b[22:0] != 23'd0);
        prod   = 48'({1'b1, a[22:0]}) * 48'({1'b1, b[22:0]});
        exp    = $signed({2'b00, a[30:23]}) + $signed({2'b00, b[30:23]}) - 10'sd127;
        if (prod[47]) begin
            mant   = prod[46:24];
            guard  = prod[23];
            sticky = |prod[22:0];
            exp    = exp + 10'sd1;
        end else begin
            mant   = prod[45:23];
            guard  = prod[22];
            sticky = |prod[21:0];
        end
        rnd      = guard & (sticky | mant[0]);
        mant_rnd = {1'b0, mant} + {23'd0, rnd};
        if (mant_rnd[23]) begin
            exp = exp + 10'sd1;
        end
        y = {sign, exp[7:0], mant_rnd[22:0]};
        if (a_nan || b_nan || (a_inf && b_zero) || (b_inf && a_zero)) begin
            y = 32'h7FC00000;
        end else if (a_inf || b_inf) begin
            y = {sign, 8'hFF, 23'd0};
        end else if (a_zero || b_zero) begin
            y = {sign, 31'd0};
        end else if (exp >= 10'sd255) begin
            y = {sign, 8'hFF, 23'd0};
        end else if (exp <= 10'sd0) begin
            y = {sign, 31'd0};
        end
    end
endmodule

// Combinational single-precision adder.
// Subnormals are treated as zero. Rounding is round-to-nearest-even.
// Exact cancellation gives +0.
module floatAdd (
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [31:0] y
);
    logic              a_zero, b_zero, a_inf, b_inf, a_nan, b_nan, a_big;
    logic [31:0]       lg, sm;
    logic [7:0]        diff;
    logic [26:0]       ml, ms, ms_sh, norm, norm_sh;
    logic [27:0]       sum;
    logic [4:0]        lz;
    logic              found, rnd;
    logic [23:0]       mant_rnd;
    logic signed [9:0] exp;

    // Align the smaller operand with three guard bits plus sticky.
    // Add or subtract the significands, renormalise, round, then resolve special operands.
    always_comb begin
        a_zero = (a[30:23] == 8'd0);
        b_zero = (b[30:23] == 8'd0);
        a_inf  = (a[30:23] == 8'hFF) && (a[22:0] == 23'd0);
        b_inf  = (b[30:23] == 8'hFF) && (b[22:0] == 23'd0);
        a_nan  = (a[30:23] == 8'hFF) && (a[22:0] != 23'd0);
        b_nan  = (b[30:23] == 8'hFF) && (b[22:0] != 23'd0);
        a_big  = (a[30:0] >= b[30:0]);
        lg     = a_big ? a : b;
        sm     = a_big ? b : a;
        diff   = lg[30:23] - sm[30:23];
        ml     = {1'b1, lg[22:0], 3'b000};
        ms     = {1'b1, sm[22:0], 3'b000};
        if (diff >= 8'd27) begin
            ms_sh = 27'd1;
        end else begin
            ms_sh    = ms >> diff;
            ms_sh[0] = ms_sh[0] | (|(ms & ((27'd1 << diff) - 27'd1)));
        end
        if (lg[31] == sm[31]) begin
            sum = {1'b0, ml} + {1'b0, ms_sh};
        end else begin
            sum = {1'b0, ml} - {1'b0, ms_sh};
        end
        exp = $signed({2'b00, lg[30:23]});
        if (sum[27]) begin
            norm = {sum[27:2], sum[1] | sum[0]};
            exp  = exp + 10'sd1;
        end else begin
            norm = sum[26:0];
        end
        lz    = 5'd0;
        found = 1'b0;
        for (int bi = 26; bi >= 0; bi--) begin
            if (!found && norm[bi]) begin
                lz    = 5'(26 - bi);
                found = 1'b1;
            end
        end
        norm_sh  = norm << lz;
        exp      = exp - $signed({5'b00000, lz});
        rnd      = norm_sh[2] & (norm_sh[1] | norm_sh[0] | norm_sh[3]);
        mant_rnd = {1'b0, norm_sh[25:3]} + {23'd0, rnd};
        if (mant_rnd[23]) begin
            exp = exp + 10'sd1;
        end
        y = {lg[31], exp[7:0], mant_rnd[22:0]};
        if (a_nan || b_nan || (a_inf && b_inf && (a[31] != b[31]))) begin
            y = 32'h7FC00000;
        end else if (a_inf) begin
            y = a;
        end else if (b_inf) begin
            y = b;
        end else if (a_zero && b_zero) begin
            y = {a[31] & b[31], 31'd0};
        end else if (a_zero) begin
            y = b;
        end else if (b_zero) begin
            y = a;
        end else if (sum == 28'd0) begin
            y = 32'd0;
        end else if (exp >= 10'sd255) begin
            y = {lg[31], 8'hFF, 23'd0};
        end else if (exp <= 10'sd0) begin
            y = {lg[31], 31'd0};
        end
    end
endmodule

// Layer controller plus K parallel MAC lanes, each owning its slice of the result store.
module conv_layer_seq #(
    parameter int DATA_WIDTH = 32,
    parameter int D          = 1,
    parameter int H          = 32,
    parameter int W          = 32,
    parameter int F          = 5,
    parameter int K          = 6,
    parameter int STRIDE     = 1
) (
    input  logic                                  clk,
    input  logic                                  reset,
    input  logic                                  start,
    input  logic                                  relu_en,
    input  logic [D*H*W*DATA_WIDTH-1:0]           image,
    input  logic [K*D*F*F*DATA_WIDTH-1:0]         filters,
    output logic                                  busy,
    output logic                                  done,
    output logic [K*((H-F)/STRIDE+1)*((W-F)/STRIDE+1)*DATA_WIDTH-1:0] outputConv
);
    localparam int OH   = (H - F) / STRIDE + 1;
    localparam int OW   = (W - F) / STRIDE + 1;
    localparam int NPIX = OH * OW;
    localparam int CW   = (D > 1) ? $clog2(D) : 1;
    localparam int FW   = (F > 1) ? $clog2(F) : 1;
    localparam int YW   = (OH > 1) ? $clog2(OH) : 1;
    localparam int XW   = (OW > 1) ? $clog2(OW) : 1;
    localparam int PW   = (NPIX > 1) ? $clog2(NPIX) : 1;
    localparam int IW   = $clog2(D * H * W * DATA_WIDTH);
    localparam int FIW  = $clog2(K * D * F * F * DATA_WIDTH);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        MAC   = 2'd1,
        WRITE = 2'd2
    } state_t;

    state_t          state_reg, state_next;
    logic [CW-1:0]   c_reg;
    logic [FW-1:0]   i_reg, j_reg;
    logic [YW-1:0]   oy_reg;
    logic [XW-1:0]   ox_reg;
    logic            relu_reg;
    logic            tap_last, pix_last;
    logic            accept, mac_en, write_en, acc_clr;
    logic [PW-1:0]   pix_idx;
    logic [IW-1:0]   img_bit;
    logic [DATA_WIDTH-1:0] img_word;

    // FSM state register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic and the lane control strobes.
    always_comb begin
        state_next = state_reg;
        accept     = 1'b0;
        mac_en     = 1'b0;
        write_en   = 1'b0;
        tap_last   = (c_reg == CW'(D - 1)) && (i_reg == FW'(F - 1)) && (j_reg == FW'(F - 1));
        pix_last   = (oy_reg == YW'(OH - 1)) && (ox_reg == XW'(OW - 1));
        case (state_reg)
            IDLE: begin
                if (start) begin
                    accept     = 1'b1;
                    state_next = MAC;
                end
            end
            MAC: begin
                mac_en = 1'b1;
                if (tap_last) begin
                    state_next = WRITE;
                end
            end
            WRITE: begin
                write_en   = 1'b1;
                state_next = pix_last ? IDLE : MAC;
            end
            default: state_next = IDLE;
        endcase
        acc_clr = accept | write_en;
    end

    // Tap and pixel counters, busy/done flags and the latched ReLU mode.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            c_reg    <= '0;
            i_reg    <= '0;
            j_reg    <= '0;
            oy_reg   <= '0;
            ox_reg   <= '0;
            relu_reg <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (start) begin
                        relu_reg <= relu_en;
                        c_reg    <= '0;
                        i_reg    <= '0;
                        j_reg    <= '0;
                        oy_reg   <= '0;
                        ox_reg   <= '0;
                        busy     <= 1'b1;
                    end
                end
                MAC: begin
                    // j is innermost and c outermost; all three wrap to zero after the last tap.
                    if (j_reg == FW'(F - 1)) begin
                        j_reg <= '0;
                        if (i_reg == FW'(F - 1)) begin
                            i_reg <= '0;
                            c_reg <= (c_reg == CW'(D - 1)) ? '0 : c_reg + 1'b1;
                        end else begin
                            i_reg <= i_reg + 1'b1;
                        end
                    end else begin
                        j_reg <= j_reg + 1'b1;
                    end
                end
                WRITE: begin
                    if (ox_reg == XW'(OW - 1)) begin
                        ox_reg <= '0;
                        oy_reg <= (oy_reg == YW'(OH - 1)) ? '0 : oy_reg + 1'b1;
                    end else begin
                        ox_reg <= ox_reg + 1'b1;
                    end
                    if (pix_last) begin
                        done <= 1'b1;
                        busy <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    // Image word under the current tap, shared by all lanes; also the raster index of the current window.
    always_comb begin
        img_bit = IW'(((int'(c_reg) * H + int'(oy_reg) * STRIDE + int'(i_reg)) * W
                       + int'(ox_reg) * STRIDE + int'(j_reg)) * DATA_WIDTH);
        img_word = image[img_bit +: DATA_WIDTH];
        pix_idx  = PW'(int'(oy_reg) * OW + int'(ox_reg));
    end

    generate
        for (genvar gi = 0; gi < K; gi++) begin : g_lane
            logic [FIW-1:0]        filt_bit;
            logic [DATA_WIDTH-1:0] acc_reg, prod, sum;
            logic [DATA_WIDTH-1:0] mem_reg [NPIX];

            // Weight of this lane's filter under the current tap.
            always_comb begin
                filt_bit = FIW'((((gi * D + int'(c_reg)) * F + int'(i_reg)) * F + int'(j_reg)) * DATA_WIDTH);
            end

            floatMult u_mul (
                .a (img_word),
                .b (filters[filt_bit +: DATA_WIDTH]),
                .y (prod)
            );

            floatAdd u_add (
                .a (acc_reg),
                .b (prod),
                .y (sum)
            );

            // Accumulate one tap per MAC cycle, restarting from +0.0 at start and after every write-back.
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    acc_reg <= '0;
                end else if (acc_clr) begin
                    acc_reg <= '0;
                end else if (mac_en) begin
                    acc_reg <= sum;
                end
            end

            // Write back the finished window, with ReLU forcing any negative value (including -0.0) to +0.0.
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    for (int p = 0; p < NPIX; p++) begin
                        mem_reg[p] <= '0;
                    end
                end else if (write_en) begin
                    mem_reg[pix_idx] <= (relu_reg && acc_reg[DATA_WIDTH-1]) ? '0 : acc_reg;
                end
            end

            for (genvar gp = 0; gp < NPIX; gp++) begin : g_out
                assign outputConv[(gi * NPIX + gp) * DATA_WIDTH +: DATA_WIDTH] = mem_reg[gp];
            end
        end
    endgenerate
endmodule

// File: tb/tb_conv_layer_seq.sv
// Scoreboard bench for conv_layer_seq across three parameter sets.
// Expected words come from integer window sums converted to single precision.
module tb_conv_layer_seq;
    localparam int A_IMG = 1*32*32*32, A_FLT = 6*1*5*5*32, A_OUT = 6*28*28*32;
    localparam int B_IMG = 2*12*12*32, B_FLT = 3*2*3*3*32, B_OUT = 3*10*10*32;
    localparam int C_IMG = 3*8*8*32,   C_FLT = 2*3*3*3*32, C_OUT = 2*3*3*32;
    localparam int PD [3] = '{1, 2, 3};
    localparam int PH [3] = '{32, 12, 8};
    localparam int PW [3] = '{32, 12, 8};
    localparam int PF [3] = '{5, 3, 3};
    localparam int PK [3] = '{6, 3, 2};
    localparam int PS [3] = '{1, 1, 2};

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic [2:0] rst_v, start_v, relu_v, busy_v, done_v;
    logic [A_IMG-1:0] img_a;  logic [A_FLT-1:0] flt_a;  logic [A_OUT-1:0] out_a;
    logic [B_IMG-1:0] img_b;  logic [B_FLT-1:0] flt_b;  logic [B_OUT-1:0] out_b;
    logic [C_IMG-1:0] img_c;  logic [C_FLT-1:0] flt_c;  logic [C_OUT-1:0] out_c;

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    int img_q[$];
    int flt_q[$];
    logic [31:0] res_q[$];
    int exp_cyc_q[3][$];
    logic [31:0] exp_w_q[3][$];

    conv_layer_seq u_a (
        .clk(clk), .reset(rst_v[0]), .start(start_v[0]), .relu_en(relu_v[0]),
        .image(img_a), .filters(flt_a), .busy(busy_v[0]), .done(done_v[0]), .outputConv(out_a));
    conv_layer_seq #(.D(2), .H(12), .W(12), .F(3), .K(3), .STRIDE(1)) u_b (
        .clk(clk), .reset(rst_v[1]), .start(start_v[1]), .relu_en(relu_v[1]),
        .image(img_b), .filters(flt_b), .busy(busy_v[1]), .done(done_v[1]), .outputConv(out_b));
    conv_layer_seq #(.D(3), .H(8), .W(8), .F(3), .K(2), .STRIDE(2)) u_c (
        .clk(clk), .reset(rst_v[2]), .start(start_v[2]), .relu_en(relu_v[2]),
        .image(img_c), .filters(flt_c), .busy(busy_v[2]), .done(done_v[2]), .outputConv(out_c));

    always @(posedge clk) cyc <= cyc + 1;

    function automatic int oh(input int id); return (PH[id] - PF[id]) / PS[id] + 1; endfunction
    function automatic int ow(input int id); return (PW[id] - PF[id]) / PS[id] + 1; endfunction
    function automatic int lat(input int id);
        return oh(id) * ow(id) * (PD[id] * PF[id] * PF[id] + 1);
    endfunction

    // Integer (|v| < 2^24) to IEEE single.
    function automatic logic [31:0] int2f(input int v);
        int a;
        int m;
        if (v == 0) return 32'd0;
        a = (v < 0) ? -v : v;
        m = 0;
        for (int b = 0; b < 31; b++) if ((a >> b) != 0) m = b;
        return {(v < 0), 8'(127 + m), 23'(a << (23 - m))};
    endfunction

    function automatic logic [31:0] word_of(input int id, input int n);
        case (id)
            0: return 32'(out_a >> (n * 32));
            1: return 32'(out_b >> (n * 32));
            default: return 32'(out_c >> (n * 32));
        endcase
    endfunction

    function automatic bit out_zero(input int id);
        case (id)
            0: return out_a == '0;
            1: return out_b == '0;
            default: return out_c == '0;
        endcase
    endfunction

    // Reference: plain window sums over the stored integer image/filters.
    task automatic model(input int id, input bit relu);
        int s;
        res_q.delete();
        for (int k = 0; k < PK[id]; k++)
            for (int y = 0; y < oh(id); y++)
                for (int x = 0; x < ow(id); x++) begin
                    s = 0;
                    for (int c = 0; c < PD[id]; c++)
                        for (int i = 0; i < PF[id]; i++)
                            for (int j = 0; j < PF[id]; j++)
                                s += img_q[(c * PH[id] + y * PS[id] + i) * PW[id] + x * PS[id] + j]
                                   * flt_q[((k * PD[id] + c) * PF[id] + i) * PF[id] + j];
                    if (relu && s < 0) s = 0;
                    res_q.push_back(int2f(s));
                end
    endtask

    task automatic drive(input int id);
        case (id)
            0: begin
                img_a = '0; flt_a = '0;
                for (int n = img_q.size() - 1; n >= 0; n--) img_a = (img_a << 32) | A_IMG'(int2f(img_q[n]));
                for (int n = flt_q.size() - 1; n >= 0; n--) flt_a = (flt_a << 32) | A_FLT'(int2f(flt_q[n]));
            end
            1: begin
                img_b = '0; flt_b = '0;
                for (int n = img_q.size() - 1; n >= 0; n--) img_b = (img_b << 32) | B_IMG'(int2f(img_q[n]));
                for (int n = flt_q.size() - 1; n >= 0; n--) flt_b = (flt_b << 32) | B_FLT'(int2f(flt_q[n]));
            end
            default: begin
                img_c = '0; flt_c = '0;
                for (int n = img_q.size() - 1; n >= 0; n--) img_c = (img_c << 32) | C_IMG'(int2f(img_q[n]));
                for (int n = flt_q.size() - 1; n >= 0; n--) flt_c = (flt_c << 32) | C_FLT'(int2f(flt_q[n]));
            end
        endcase
    endtask

    task automatic set_const(input int id, input int iv, input int fv);
        img_q.delete(); flt_q.delete();
        for (int n = 0; n < PD[id] * PH[id] * PW[id]; n++) img_q.push_back(iv);
        for (int n = 0; n < PK[id] * PD[id] * PF[id] * PF[id]; n++) flt_q.push_back(fv);
    endtask

    task automatic set_rand(input int id);
        img_q.delete(); flt_q.delete();
        for (int n = 0; n < PD[id] * PH[id] * PW[id]; n++) img_q.push_back(int'($urandom_range(16)) - 8);
        for (int n = 0; n < PK[id] * PD[id] * PF[id] * PF[id]; n++) flt_q.push_back(int'($urandom_range(16)) - 8);
    endtask

    task automatic wait_cyc(input int target);
        while (cyc < target) begin @(posedge clk); #1; end
    endtask

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        tests++;
        if (got !== want) begin
            fails++;
            $display("FAIL %s got %08h want %08h", name, got, want);
        end
    endtask

    // Push expectations, pulse start, then flip relu_en to show it is latched.
    task automatic launch(input int id, input bit relu, output int s);
        model(id, relu);
        foreach (res_q[n]) exp_w_q[id].push_back(res_q[n]);
        @(negedge clk);
        relu_v[id] = relu;
        start_v[id] = 1'b1;
        @(posedge clk); #1;
        s = cyc;
        start_v[id] = 1'b0;
        exp_cyc_q[id].push_back(s + lat(id));
        check("busy_after_start", 32'(busy_v[id]), 32'd1);
        relu_v[id] = ~relu;
    endtask

    task automatic wait_done(input int id);
        int t = 0;
        while (exp_cyc_q[id].size() != 0 && t < lat(id) + 200) begin @(negedge clk); t++; end
        @(posedge clk); #1;
        if (exp_cyc_q[id].size() != 0) begin
            tests++; fails++;
            $display("FAIL done_timeout dut%0d got no done want done within %0d cycles", id, lat(id) + 200);
            exp_cyc_q[id].delete(); exp_w_q[id].delete();
        end
    endtask

    // Monitor: every done pulse pops one expected run and checks latency, busy and all words.
    always @(negedge clk) begin
        for (int id = 0; id < 3; id++) begin
            if (done_v[id] === 1'b1) begin
                tests++;
                if (exp_cyc_q[id].size() == 0) begin
                    fails++;
                    $display("FAIL unexpected_done dut%0d got done at cycle %0d want no run pending", id, cyc);
                end else begin
                    int ec;
                    int bad;
                    logic [31:0] ew;
                    ec = exp_cyc_q[id].pop_front();
                    if (cyc != ec) begin
                        fails++;
                        $display("FAIL latency dut%0d got done at cycle %0d want %0d", id, cyc, ec);
                    end
                    tests++;
                    if (busy_v[id] !== 1'b0) begin
                        fails++;
                        $display("FAIL busy_at_done dut%0d got %b want 0", id, busy_v[id]);
                    end
                    bad = 0;
                    for (int n = 0; n < PK[id] * oh(id) * ow(id); n++) begin
                        ew = exp_w_q[id].pop_front();
                        tests++;
                        if (word_of(id, n) !== ew) begin
                            fails++; bad++;
                            $display("FAIL word dut%0d idx %0d got %08h want %08h", id, n, word_of(id, n), ew);
                        end
                    end
                    $display("[TB] dut%0d run done at cycle %0d, %0d words checked, %0d wrong",
                             id, cyc, PK[id] * oh(id) * ow(id), bad);
                end
            end
        end
    end

    initial begin
        int s;
        rst_v = 3'b111; start_v = 3'b000; relu_v = 3'b000;
        img_a = '0; flt_a = '0; img_b = '0; flt_b = '0; img_c = '0; flt_c = '0;
        repeat (3) @(posedge clk);
        #1;
        for (int id = 0; id < 3; id++) begin
            check("reset_busy", 32'(busy_v[id]), 32'd0);
            check("reset_done", 32'(done_v[id]), 32'd0);
            check("reset_out_zero", 32'(out_zero(id)), 32'd1);
        end
        @(negedge clk); rst_v = 3'b000;

        // Stride-2 multi-channel instance: all ones, then random with ReLU.
        set_const(2, 1, 1); drive(2);
        launch(2, 1'b0, s); wait_done(2);
        check("c_word_27", word_of(2, 17), 32'h41D80000);
        set_rand(2); drive(2);
        launch(2, 1'b1, s); wait_done(2);

        // Negative results without and with ReLU.
        set_const(1, 4, -1); drive(1);
        launch(1, 1'b0, s); wait_done(1);
        check("b_word_neg72", word_of(1, 0), 32'hC2900000);
        launch(1, 1'b1, s); wait_done(1);
        check("b_word_relu0", word_of(1, 299), 32'h00000000);

        // Start pulses while busy are ignored.
        set_rand(1); drive(1);
        launch(1, 1'b0, s);
        wait_cyc(s + 10);
        @(negedge clk); start_v[1] = 1'b1; @(negedge clk); start_v[1] = 1'b0;
        wait_cyc(s + 500);
        @(negedge clk); start_v[1] = 1'b1; @(negedge clk); start_v[1] = 1'b0;
        wait_done(1);

        // Start held through done: second run accepted the edge after done.
        set_rand(1); drive(1);
        model(1, 1'b1);
        foreach (res_q[n]) exp_w_q[1].push_back(res_q[n]);
        foreach (res_q[n]) exp_w_q[1].push_back(res_q[n]);
        @(negedge clk); relu_v[1] = 1'b1; start_v[1] = 1'b1;
        @(posedge clk); #1; s = cyc;
        exp_cyc_q[1].push_back(s + lat(1));
        exp_cyc_q[1].push_back(s + 2 * lat(1) + 1);
        wait_cyc(s + lat(1) + 1);
        check("busy_reasserted", 32'(busy_v[1]), 32'd1);
        start_v[1] = 1'b0;
        wait_done(1);

        // Asynchronous reset in the middle of a run, then a clean rerun.
        set_rand(1); drive(1);
        launch(1, 1'b0, s);
        wait_cyc(s + 1000);
        #2 rst_v[1] = 1'b1;
        #1;
        check("midreset_busy", 32'(busy_v[1]), 32'd0);
        check("midreset_done", 32'(done_v[1]), 32'd0);
        check("midreset_out_zero", 32'(out_zero(1)), 32'd1);
        exp_cyc_q[1].delete(); exp_w_q[1].delete();
        @(negedge clk); rst_v[1] = 1'b0;
        launch(1, 1'b0, s); wait_done(1);
        set_rand(1); drive(1);
        launch(1, 1'b1, s); wait_done(1);

        // Default instance: constant image with two filter magnitudes.
        img_q.delete(); flt_q.delete();
        for (int n = 0; n < 1024; n++) img_q.push_back(4);
        for (int k = 0; k < 6; k++)
            for (int n = 0; n < 25; n++) flt_q.push_back((k >= 2 && k <= 4) ? 2 : 4);
        drive(0);
        launch(0, 1'b0, s);
        wait_cyc(s + 10000);
        check("a_busy_midrun", 32'(busy_v[0]), 32'd1);
        wait_done(0);
        check("a_word_f0", word_of(0, 0), 32'h43C80000);
        check("a_word_f2", word_of(0, 2 * 784), 32'h43480000);
        check("a_word_f5", word_of(0, 5 * 784 + 783), 32'h43C80000);

        // Default instance: ramp image, filter 0 all ones, other filters random.
        img_q.delete(); flt_q.delete();
        for (int r = 0; r < 32; r++)
            for (int x = 0; x < 32; x++) img_q.push_back(r * 32 + x);
        for (int n = 0; n < 25; n++) flt_q.push_back(1);
        for (int n = 25; n < 150; n++) flt_q.push_back(int'($urandom_range(6)) - 3);
        drive(0);
        launch(0, 1'b0, s); wait_done(0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
